// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX skid stage: control payload, FSM state and bubble constant.
package id_ex_pkg;

    typedef struct packed {
        logic [3:0] ALUOp;
        logic [3:0] entrada_alu_control;
        logic [1:0] AuipcLui;
        logic       Branch;
        logic       MemRead;
        logic       MemtoReg;
        logic       MemWrite;
        logic       RegWrite;
        logic       ALUSrc;
    } ctrl_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/id_ex_skid_entry.sv
// One ID/EX payload slot: load-enabled register with asynchronous clear.
module id_ex_entry
    import id_ex_pkg::*;
#(
    parameter int SIZE = 32
) (
    input  logic            CLK,
    input  logic            RESET,
    input  logic            load,
    input  logic [SIZE-1:0] pc_d,
    input  logic [SIZE-1:0] dsalida_d,
    input  logic [SIZE-1:0] imm_d,
    input  logic [SIZE-1:0] read_data1_d,
    input  logic [SIZE-1:0] read_data2_d,
    input  logic [4:0]      wrin_d,
    input  ctrl_t           ctrl_d,
    output logic [SIZE-1:0] pc_q,
    output logic [SIZE-1:0] dsalida_q,
    output logic [SIZE-1:0] imm_q,
    output logic [SIZE-1:0] read_data1_q,
    output logic [SIZE-1:0] read_data2_q,
    output logic [4:0]      wrin_q,
    output ctrl_t           ctrl_q
);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pc_q         <= '0;
            dsalida_q    <= '0;
            imm_q        <= '0;
            read_data1_q <= '0;
            read_data2_q <= '0;
            wrin_q       <= '0;
            ctrl_q       <= CTRL_BUBBLE;
        end else if (load) begin
            pc_q         <= pc_d;
            dsalida_q    <= dsalida_d;
            imm_q        <= imm_d;
            read_data1_q <= read_data1_d;
            read_data2_q <= read_data2_d;
            wrin_q       <= wrin_d;
            ctrl_q       <= ctrl_d;
        end
    end

endmodule

// File: rtl/id_ex_skid.sv
// ID/EX pipeline stage with registered ready, two-entry skid buffer, flush and stall counter.
// state | meaning
// EMPTY | main entry invalid
// FULL  | main entry valid, skid entry empty
// SKID  | main and skid entries both valid
module id_ex_skid
    import id_ex_pkg::*;
#(
    parameter int SIZE  = 32,
    parameter int CNT_W = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             flush,
    input  logic             valid_ID,
    output logic             ready_ID,
    input  logic [SIZE-1:0]  PC_ID,
    input  logic [SIZE-1:0]  dsalida_ID,
    input  logic [SIZE-1:0]  imm_ID,
    input  logic [SIZE-1:0]  read_data1_ID,
    input  logic [SIZE-1:0]  read_data2_ID,
    input  logic [4:0]       wrin_ID,
    input  ctrl_t            ctrl_ID,
    output logic             valid_EX,
    input  logic             ready_EX,
    output logic [SIZE-1:0]  PC_EX,
    output logic [SIZE-1:0]  dsalida_EX,
    output logic [SIZE-1:0]  imm_EX,
    output logic [SIZE-1:0]  read_data1_EX,
    output logic [SIZE-1:0]  read_data2_EX,
    output logic [4:0]       wrin_EX,
    output ctrl_t            ctrl_EX,
    output logic [CNT_W-1:0] stall_cnt
);

    state_t state, state_nxt;
    logic   accept, consume;
    logic   load_main, load_skid, main_from_skid;

    logic [SIZE-1:0] sk_pc, sk_dsalida, sk_imm, sk_rd1, sk_rd2;
    logic [4:0]      sk_wrin;
    ctrl_t           sk_ctrl, main_ctrl;

    assign accept  = valid_ID & ready_ID;
    assign consume = valid_EX & ready_EX;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= EMPTY;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: if (accept) begin
                    state_nxt = FULL;
                    load_main = 1'b1;
                end
                FULL: begin
                    if (accept && consume) begin
                        load_main = 1'b1;
                    end else if (consume) begin
                        state_nxt = EMPTY;
                    end else if (accept) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end
                end
                SKID: if (consume) begin
                    state_nxt      = FULL;
                    load_main      = 1'b1;
                    main_from_skid = 1'b1;
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        valid_EX = (state != EMPTY);
        ready_ID = (state != SKID);
    end

    id_ex_entry #(.SIZE(SIZE)) u_skid (
        .CLK          (CLK),
        .RESET        (RESET),
        .load         (load_skid),
        .pc_d         (PC_ID),
        .dsalida_d    (dsalida_ID),
        .imm_d        (imm_ID),
        .read_data1_d (read_data1_ID),
        .read_data2_d (read_data2_ID),
        .wrin_d       (wrin_ID),
        .ctrl_d       (ctrl_ID),
        .pc_q         (sk_pc),
        .dsalida_q    (sk_dsalida),
        .imm_q        (sk_imm),
        .read_data1_q (sk_rd1),
        .read_data2_q (sk_rd2),
        .wrin_q       (sk_wrin),
        .ctrl_q       (sk_ctrl)
    );

    // Main entry refills from the skid slot first so ordering stays FIFO.
    id_ex_entry #(.SIZE(SIZE)) u_main (
        .CLK          (CLK),
        .RESET        (RESET),
        .load         (load_main),
        .pc_d         (main_from_skid ? sk_pc      : PC_ID),
        .dsalida_d    (main_from_skid ? sk_dsalida : dsalida_ID),
        .imm_d        (main_from_skid ? sk_imm     : imm_ID),
        .read_data1_d (main_from_skid ? sk_rd1     : read_data1_ID),
        .read_data2_d (main_from_skid ? sk_rd2     : read_data2_ID),
        .wrin_d       (main_from_skid ? sk_wrin    : wrin_ID),
        .ctrl_d       (main_from_skid ? sk_ctrl    : ctrl_ID),
        .pc_q         (PC_EX),
        .dsalida_q    (dsalida_EX),
        .imm_q        (imm_EX),
        .read_data1_q (read_data1_EX),
        .read_data2_q (read_data2_EX),
        .wrin_q       (wrin_EX),
        .ctrl_q       (main_ctrl)
    );

    // Stale payload may sit in the main register; never let it look like a real op.
    assign ctrl_EX = valid_EX ? main_ctrl : CTRL_BUBBLE;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)
            stall_cnt <= '0;
        else if (valid_EX && !ready_EX && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
    end

endmodule

// File: tb/tb_id_ex_skid.sv
// Bench for id_ex_skid: directed scenarios plus random traffic against a queue-based model.
module tb_id_ex_skid;
    import id_ex_pkg::*;

    localparam int SIZE    = 32;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic [SIZE-1:0] pc, ds, imm, r1, r2;
        logic [4:0]      wr;
        ctrl_t           ctrl;
    } pl_t;

    logic             CLK, RESET, flush, valid_ID, ready_ID, valid_EX, ready_EX;
    logic [SIZE-1:0]  PC_ID, dsalida_ID, imm_ID, read_data1_ID, read_data2_ID;
    logic [SIZE-1:0]  PC_EX, dsalida_EX, imm_EX, read_data1_EX, read_data2_EX;
    logic [4:0]       wrin_ID, wrin_EX;
    ctrl_t            ctrl_ID, ctrl_EX;
    logic [CNT_W-1:0] stall_cnt;

    pl_t q[$];
    int  cnt;
    int  n_checks;
    int  n_fail;

    id_ex_skid #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET(RESET), .flush(flush),
        .valid_ID(valid_ID), .ready_ID(ready_ID),
        .PC_ID(PC_ID), .dsalida_ID(dsalida_ID), .imm_ID(imm_ID),
        .read_data1_ID(read_data1_ID), .read_data2_ID(read_data2_ID),
        .wrin_ID(wrin_ID), .ctrl_ID(ctrl_ID),
        .valid_EX(valid_EX), .ready_EX(ready_EX),
        .PC_EX(PC_EX), .dsalida_EX(dsalida_EX), .imm_EX(imm_EX),
        .read_data1_EX(read_data1_EX), .read_data2_EX(read_data2_EX),
        .wrin_EX(wrin_EX), .ctrl_EX(ctrl_EX), .stall_cnt(stall_cnt)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic ctrl_t rand_ctrl();
        logic [31:0] t;
        t = $urandom;
        return t[$bits(ctrl_t)-1:0];
    endfunction

    task automatic check_zero_outputs();
        check_val("rst_PC_EX", PC_EX, 0);
        check_val("rst_dsalida_EX", dsalida_EX, 0);
        check_val("rst_imm_EX", imm_EX, 0);
        check_val("rst_rd1_EX", read_data1_EX, 0);
        check_val("rst_rd2_EX", read_data2_EX, 0);
        check_val("rst_wrin_EX", wrin_EX, 0);
        check_val("rst_ctrl_EX", ctrl_EX, 0);
    endtask

    task automatic check_all();
        check_val("valid_EX", valid_EX, q.size() > 0);
        check_val("ready_ID", ready_ID, q.size() < 2);
        check_val("stall_cnt", stall_cnt, cnt);
        if (q.size() > 0) begin
            check_val("PC_EX", PC_EX, q[0].pc);
            check_val("dsalida_EX", dsalida_EX, q[0].ds);
            check_val("imm_EX", imm_EX, q[0].imm);
            check_val("rd1_EX", read_data1_EX, q[0].r1);
            check_val("rd2_EX", read_data2_EX, q[0].r2);
            check_val("wrin_EX", wrin_EX, q[0].wr);
            check_val("ctrl_EX", ctrl_EX, q[0].ctrl);
        end else begin
            check_val("bubble_ctrl",
                      {ctrl_EX.Branch, ctrl_EX.MemRead, ctrl_EX.MemWrite, ctrl_EX.RegWrite}, 0);
        end
    endtask

    // Drive one cycle of inputs, advance the model at the edge, check at the falling edge.
    task automatic step(input logic f, input logic v, input logic r,
                        input logic [SIZE-1:0] pc, input ctrl_t c);
        pl_t p;
        logic acc, cons;
        flush         = f;
        valid_ID      = v;
        ready_EX      = r;
        PC_ID         = pc;
        dsalida_ID    = $urandom;
        imm_ID        = $urandom;
        read_data1_ID = $urandom;
        read_data2_ID = $urandom;
        wrin_ID       = 5'($urandom);
        ctrl_ID       = c;
        p = '{pc: PC_ID, ds: dsalida_ID, imm: imm_ID, r1: read_data1_ID,
              r2: read_data2_ID, wr: wrin_ID, ctrl: ctrl_ID};
        @(posedge CLK);
        acc  = v && (q.size() < 2);
        cons = r && (q.size() > 0);
        if (q.size() > 0 && !r && cnt < CNT_MAX) cnt++;
        if (f) begin
            q.delete();
        end else begin
            if (cons) void'(q.pop_front());
            if (acc) q.push_back(p);
        end
        @(negedge CLK);
        check_all();
    endtask

    // Called right after a falling edge; reset pulse lies entirely between clock edges.
    task automatic async_reset();
        #2 RESET = 1'b1;
        #1;
        q.delete();
        cnt = 0;
        check_all();
        check_zero_outputs();
        #1 RESET = 1'b0;
    endtask

    initial begin
        ctrl_t mw;
        n_checks = 0;
        n_fail   = 0;
        cnt      = 0;
        RESET = 1'b1; flush = 1'b0; valid_ID = 1'b0; ready_EX = 1'b0;
        PC_ID = '0; dsalida_ID = '0; imm_ID = '0; read_data1_ID = '0; read_data2_ID = '0;
        wrin_ID = '0; ctrl_ID = CTRL_BUBBLE;
        #7;
        check_all();
        check_zero_outputs();
        @(negedge CLK);
        RESET = 1'b0;
        check_all();
        check_zero_outputs();

        // stream at full rate
        step(0, 1, 1, 32'h0, rand_ctrl());
        step(0, 1, 1, 32'h4, rand_ctrl());
        step(0, 1, 1, 32'h8, rand_ctrl());
        step(0, 0, 1, 32'hdead, rand_ctrl());

        // back-pressure into skid, then FIFO drain
        step(0, 1, 0, 32'h10, rand_ctrl());
        step(0, 1, 0, 32'h14, rand_ctrl());
        check_val("bp_ready_ID", ready_ID, 0);
        step(0, 1, 0, 32'h18, rand_ctrl());
        step(0, 0, 0, 32'h0, rand_ctrl());
        step(0, 0, 1, 32'h0, rand_ctrl());
        check_val("bp_first_out", PC_EX, 32'h14);
        step(0, 0, 1, 32'h0, rand_ctrl());

        // flush in SKID with a concurrent offer
        step(0, 1, 0, 32'h30, rand_ctrl());
        step(0, 1, 0, 32'h34, rand_ctrl());
        step(1, 1, 0, 32'h20, rand_ctrl());
        check_val("flush_regwrite", ctrl_EX.RegWrite, 0);
        step(0, 0, 1, 32'h0, rand_ctrl());

        // bubble safety after a store drains
        mw = rand_ctrl();
        mw.MemWrite = 1'b1;
        step(0, 1, 1, 32'h40, mw);
        step(0, 0, 1, 32'h0, rand_ctrl());
        check_val("bubble_memwrite", ctrl_EX.MemWrite, 0);

        // stall counter saturation
        step(0, 1, 0, 32'h50, rand_ctrl());
        for (int i = 0; i < 20; i++) step(0, 0, 0, 32'h0, rand_ctrl());
        check_val("sat_stall_cnt", stall_cnt, CNT_MAX);

        // asynchronous reset while in SKID
        step(0, 1, 0, 32'h60, rand_ctrl());
        async_reset();
        step(0, 1, 0, 32'h64, rand_ctrl());
        step(0, 1, 0, 32'h68, rand_ctrl());
        async_reset();
        step(0, 0, 1, 32'h0, rand_ctrl());

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 70),
                 ($urandom_range(0, 99) < 60), $urandom, rand_ctrl());
            if ($urandom_range(0, 299) == 0) async_reset();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
